axis_master_out: RTL and testbench

Output stage of the resizer, directly downstream of the lane buffer. Pops packed lane entries from the buffer's master side and drops entries with no kept lanes. Presents the rest as an AXI-Stream master beat (tdata/tkeep/tlast) through a two-register skid stage, so `master_entry_ready` never depends combinationally on `m_axis_tready`. Also keeps packet/beat counters and a sticky lane-format error flag.

---
 rtl/resizer_pkg.sv | 21 ++
 rtl/axis_master_out_if.sv | 18 +
 rtl/axis_skid_reg.sv | 55 +++++
 rtl/axis_master_out.sv | 95 +++++++++
 tb/tb_axis_master_out.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/resizer_pkg.sv
// resizer_pkg: shared definitions for the resizer datapath (packer, lane
// buffer, output stage).
//   KEEP_BIT / LAST_BIT : flag offsets above the data field inside a lane
//   lane_w()            : lane width for a given data width
//   lane_t              : lane layout at the default 8-bit data width
package resizer_pkg;

    localparam int KEEP_BIT = 1;
    localparam int LAST_BIT = 0;

    function automatic int lane_w(input int t_data_width);
        return t_data_width + 2;
    endfunction

    typedef struct packed {
        logic       keep;
        logic       last;
        logic [7:0] data;
    } lane_t;

endpackage

// File: rtl/axis_master_out_if.sv
// axis_master_out_if: AXI-Stream beat bus (tdata/tkeep/tlast/tvalid/tready).
//   master modport : drives payload + tvalid, receives tready
//   slave modport  : the reverse
interface axis_master_out_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int M_KEEP_WIDTH = 2
) ();

    logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] tdata;
    logic [M_KEEP_WIDTH-1:0]              tkeep;
    logic                                 tlast;
    logic                                 tvalid;
    logic                                 tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: two-register (main + skid) pipeline stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_data  : upstream beat
//   in_ready            : upstream may push; depends only on skid state and rst
//   out_valid / out_data: main register, drives the downstream bus
//   out_ready           : downstream accept
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Ready comes straight from the skid flag, so it never sees out_ready.
    assign in_ready = !skid_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            // Main is free this cycle: skid has priority, new beat refills skid.
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                if (in_valid) begin
                    skid_data <= in_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (in_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid) begin
            // Main stalled: park the beat in skid.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/axis_master_out.sv
// axis_master_out: resizer output stage. Pops lane entries from the lane
// buffer, drops null entries, and presents the rest as AXI-Stream beats
// through a main/skid register pair.
//   clk, rst           : clock, synchronous active-high reset
//   master_entry       : packed lanes {keep, last, data} x M_KEEP_WIDTH
//   underflow          : buffer empty (entry invalid)
//   master_entry_ready : pop request to the buffer
//   m_axis             : AXI-Stream master bus
//   pkt_cnt, beat_cnt  : wrapping counts of transferred tlast beats / beats
//   fmt_err            : sticky lane-format error
module axis_master_out
    import resizer_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int M_KEEP_WIDTH = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [(2+T_DATA_WIDTH)*M_KEEP_WIDTH-1:0]  master_entry,
    input  logic                                      underflow,
    output logic                                      master_entry_ready,
    axis_master_out_if.master                         m_axis,
    output logic [CNT_WIDTH-1:0]                      pkt_cnt,
    output logic [CNT_WIDTH-1:0]                      beat_cnt,
    output logic                                      fmt_err
);

    localparam int LANE_W = lane_w(T_DATA_WIDTH);
    localparam int DATA_W = T_DATA_WIDTH * M_KEEP_WIDTH;
    localparam int PAY_W  = 1 + M_KEEP_WIDTH + DATA_W;

    logic [M_KEEP_WIDTH-1:0] keep;
    logic [M_KEEP_WIDTH-1:0] last;
    logic [DATA_W-1:0]       data;

    for (genvar g = 0; g < M_KEEP_WIDTH; g++) begin : g_lane
        assign keep[g] = master_entry[g*LANE_W + T_DATA_WIDTH + KEEP_BIT];
        assign last[g] = master_entry[g*LANE_W + T_DATA_WIDTH + LAST_BIT];
        assign data[g*T_DATA_WIDTH +: T_DATA_WIDTH] = master_entry[g*LANE_W +: T_DATA_WIDTH];
    end

    // A kept lane above a kept-last lane means the packer spilled data past
    // the packet end.
    logic order_err;
    logic seen_last;
    always_comb begin
        order_err = 1'b0;
        seen_last = 1'b0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (keep[i] && seen_last) order_err = 1'b1;
            if (keep[i] && last[i])   seen_last = 1'b1;
        end
    end

    logic pop;
    logic beat_in;
    logic tlast_in;
    logic lane_err;
    logic [PAY_W-1:0] out_data;

    assign pop      = master_entry_ready && !underflow;
    assign beat_in  = pop && (|keep);
    assign tlast_in = |(keep & last);
    // Also covers a null entry carrying a last bit.
    assign lane_err = (|(last & ~keep)) || order_err;

    axis_skid_reg #(.WIDTH(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat_in),
        .in_data   ({tlast_in, keep, data}),
        .in_ready  (master_entry_ready),
        .out_valid (m_axis.tvalid),
        .out_data  (out_data),
        .out_ready (m_axis.tready)
    );

    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
            fmt_err  <= 1'b0;
        end else begin
            if (m_axis.tvalid && m_axis.tready) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (m_axis.tlast) pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (pop && lane_err) fmt_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_master_out.sv
module tb_axis_master_out;

    localparam int TDW = 8;
    localparam int MKW = 2;
    localparam int CW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic [(2+TDW)*MKW-1:0]   master_entry;
    logic                     underflow;
    logic                     master_entry_ready;
    logic [CW-1:0]            pkt_cnt;
    logic [CW-1:0]            beat_cnt;
    logic                     fmt_err;

    axis_master_out_if #(.T_DATA_WIDTH(TDW), .M_KEEP_WIDTH(MKW)) m_axis ();

    axis_master_out #(.T_DATA_WIDTH(TDW), .M_KEEP_WIDTH(MKW), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .master_entry       (master_entry),
        .underflow          (underflow),
        .master_entry_ready (master_entry_ready),
        .m_axis             (m_axis),
        .pkt_cnt            (pkt_cnt),
        .beat_cnt           (beat_cnt),
        .fmt_err            (fmt_err)
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [18:0] got[$];

    // Observe pops and transferred beats at the active edge.
    always @(posedge clk) begin
        if (master_entry_ready && !underflow) pops++;
        if (m_axis.tvalid && m_axis.tready)
            got.push_back({m_axis.tlast, m_axis.tkeep, m_axis.tdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] bp [5];
    logic [18:0] bp_exp [5];
    int  base;
    int  idx;
    logic p;

    initial begin
        // ---- reset ----
        rst = 1'b1; underflow = 1'b0; master_entry = '0; m_axis.tready = 1'b0;
        base = pops;
        repeat (3) step();
        chk("rst_ready",  32'(master_entry_ready), 0);
        chk("rst_tvalid", 32'(m_axis.tvalid), 0);
        chk("rst_tdata",  32'(m_axis.tdata), 0);
        chk("rst_tkeep",  32'(m_axis.tkeep), 0);
        chk("rst_tlast",  32'(m_axis.tlast), 0);
        chk("rst_cnts",   32'({pkt_cnt, beat_cnt}), 0);
        chk("rst_fmt",    32'(fmt_err), 0);
        chk("rst_pops",   32'(pops - base), 0);
        rst = 1'b0; underflow = 1'b1;
        step();
        chk("rel_ready",  32'(master_entry_ready), 1);

        // ---- full beat ----
        m_axis.tready = 1'b1; master_entry = 20'hCF2A5; underflow = 1'b0;
        step();
        underflow = 1'b1;
        chk("full_tvalid", 32'(m_axis.tvalid), 1);
        chk("full_tdata",  32'(m_axis.tdata), 32'h3CA5);
        chk("full_tkeep",  32'(m_axis.tkeep), 3);
        chk("full_tlast",  32'(m_axis.tlast), 1);
        step();
        chk("full_pkt",    32'(pkt_cnt), 1);
        chk("full_beat",   32'(beat_cnt), 1);
        chk("full_idle",   32'(m_axis.tvalid), 0);

        // ---- null entry ----
        base = pops; master_entry = 20'h00000; underflow = 1'b0;
        step();
        underflow = 1'b1;
        chk("null_pops",   32'(pops - base), 1);
        chk("null_tvalid", 32'(m_axis.tvalid), 0);
        step();
        chk("null_cnts",   32'({pkt_cnt, beat_cnt}), 32'h11);
        chk("null_fmt",    32'(fmt_err), 0);

        // ---- backpressure ----
        for (int k = 0; k < 5; k++) begin
            bp[k]     = {1'b1, (k == 4), 8'(16 + k), 1'b1, 1'b0, 8'(32 + k)};
            bp_exp[k] = {(k == 4), 2'b11, 8'(16 + k), 8'(32 + k)};
        end
        base = pops; got.delete(); m_axis.tready = 1'b0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            master_entry = bp[idx]; underflow = 1'b0;
            @(negedge clk);
            if (c == 2) chk("bp_ready_c3", 32'(master_entry_ready), 0);
            p = master_entry_ready;
            step();
            if (p) idx++;
        end
        chk("bp_pops",   32'(pops - base), 2);
        chk("bp_hold_v", 32'(m_axis.tvalid), 1);
        chk("bp_hold_d", 32'(m_axis.tdata), 32'h1020);
        m_axis.tready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            underflow = (idx >= 5);
            if (idx < 5) master_entry = bp[idx];
            @(negedge clk);
            p = master_entry_ready && !underflow;
            step();
            if (p) idx++;
        end
        underflow = 1'b1;
        step(); step();
        chk("bp_nbeats", 32'(got.size()), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("bp_beat%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hx, 32'(bp_exp[k]));
        chk("bp_pops_all", 32'(pops - base), 5);
        chk("bp_cnts",   32'({pkt_cnt, beat_cnt}), 32'h26);
        chk("bp_idle",   32'(m_axis.tvalid), 0);

        // ---- format error: lane0 keep+last, lane1 kept above it ----
        master_entry = 20'h80300; underflow = 1'b0;
        step();
        underflow = 1'b1;
        chk("fmt_tvalid", 32'(m_axis.tvalid), 1);
        chk("fmt_tdata",  32'(m_axis.tdata), 0);
        chk("fmt_tkeep",  32'(m_axis.tkeep), 3);
        chk("fmt_tlast",  32'(m_axis.tlast), 1);
        chk("fmt_flag",   32'(fmt_err), 1);
        step();
        chk("fmt_cnts",   32'({pkt_cnt, beat_cnt}), 32'h37);

        // ---- reset clears, null entry with last bit, counter wrap ----
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst2_fmt",  32'(fmt_err), 0);
        chk("rst2_cnts", 32'({pkt_cnt, beat_cnt}), 0);
        master_entry = 20'h00100; underflow = 1'b0;
        step();
        underflow = 1'b1;
        chk("nulllast_fmt",    32'(fmt_err), 1);
        chk("nulllast_tvalid", 32'(m_axis.tvalid), 0);
        for (int k = 0; k < 17; k++) begin
            master_entry = {10'h000, 2'b11, 8'(k)}; underflow = 1'b0;
            step();
        end
        underflow = 1'b1;
        step(); step();
        chk("wrap_pkt",  32'(pkt_cnt), 1);
        chk("wrap_beat", 32'(beat_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
